simt_div_stack: RTL and testbench
=================================

# simt_div_stack

Parametrised SIMT divergence stack for the SMCore scheduler. It tracks per-lane active masks across nested data-dependent branches, along with the reconvergence PC, parent mask and else-taken state of each nesting level. It gives the scheduler registered top-of-stack mask/PC, uniformity flags relative to the parent level, and sticky error reporting for overflow, underflow and illegal command sequences.

## Interface
- N_CORES, 4, lanes per warp (mask width)
- DEPTH, 8, stack entries including base level; ≥2
- PC_W, 16, reconvergence PC width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- load  in  1  set base-level mask from d_in (warp launch)
- push  in  1  enter branch: predicate d_in, reconvergence PC rpc_in
- els  in  1  switch current level to its else-path
- pop  in  1  reconverge: leave current level
- d_in  in  N_CORES  lane predicate / launch mask
- rpc_in  in  PC_W  reconvergence PC for push
- err_clr  in  1  clear sticky error bits
- tos_mask  out  N_CORES  active mask of current level
- tos_pc  out  PC_W  reconvergence PC of current level (0 at base)
- depth  out  clog2(DEPTH)  current level index, 0 = base
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH-1
- all_true  out  1  every parent-enabled lane active
- all_false  out  1  no lane active
- err  out  3  sticky {illegal, underflow, overflow}

## Operation
- Each entry stores: mask, parent mask, rpc, else_done.
- Base entry reset: mask = parent = all ones, rpc = 0, else_done = 1.
- load (depth==0 only): mask = parent = d_in.
- push: depth+1; new mask = d_in & mask[depth]; parent = mask[depth]; rpc = rpc_in; else_done = 0.
- els: mask = parent & ~mask; else_done = 1. Only legal once per level and never at base.
- pop: depth−1; popped entry contents are irrelevant afterwards.
- Boundary and illegal conditions (the command is ignored and state is unchanged):
  - push when full → err[0].
  - pop when empty → err[1].
  - els at base or with else_done=1 → err[2].
  - load at depth≠0 → err[2].
  - More than one of {load, push, els, pop} asserted in a cycle → err[2].
- all_true = ((mask | ~parent) == all ones); all_false = (mask == 0).
- Push with an all-zero effective mask is legal; all_false=1 lets the scheduler skip the path.
- err bits are sticky until err_clr. err_clr in the same cycle as a new error: the error wins (bit set).

## Timing
- All state updates on rising clk. Every output is a function of registered state only, so there is no combinational path from inputs to outputs.
- A command at edge k is visible on all outputs after edge k (1-cycle latency). Back-to-back commands every cycle are supported.
- Asynchronous assertion of reset_n=0 at any time, including mid-nest, returns all state to reset immediately.
- Reset output values:
  - tos_mask = all ones, tos_pc = 0, depth = 0.
  - empty=1, full=0, all_true=1, all_false=0, err=0.
- Deassertion of reset_n is synchronous to clk externally. The first command is accepted on the first edge with reset_n=1.
- Idle cycles (no command) hold all state.

## Test plan
- Reset, then load d_in=4'b0111 → tos_mask=0111, all_true=1, depth=0, empty=1.
- Push d_in=1010, rpc_in=0x40 after the 0111 load → tos_mask=0010, tos_pc=0x40, depth=1, all_true=0. Then els → tos_mask=0101. Then pop → tos_mask=0111, depth=0.
- Nest pushes to DEPTH-1 (full=1), one more push → err=001 with state unchanged. Pop to empty, one more pop → err=011. err_clr → err=000.
- Illegal sequences: els at base; second els at the same level; push+pop together; load at depth 2. Each → err[2]=1 and all outputs unchanged.
- Push d_in=0000 → all_false=1, all_true=0. Then els → mask = parent, all_true=1.
- Assert reset_n low asynchronously mid-cycle at depth 3 → outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/simt_div_stack.sv
`timescale 1ns/1ps
// SIMT divergence stack: per-level active mask, parent mask, reconvergence
// PC and else-taken flag, with registered top-of-stack outputs and sticky
// error flags for overflow, underflow and illegal command sequences.
module simt_div_stack #(
    parameter int N_CORES = 4,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load,
    input  logic                       push,
    input  logic                       els,
    input  logic                       pop,
    input  logic [N_CORES-1:0]         d_in,
    input  logic [PC_W-1:0]            rpc_in,
    input  logic                       err_clr,
    output logic [N_CORES-1:0]         tos_mask,
    output logic [PC_W-1:0]            tos_pc,
    output logic [$clog2(DEPTH)-1:0]   depth,
    output logic                       empty,
    output logic                       full,
    output logic                       all_true,
    output logic                       all_false,
    output logic [2:0]                 err
);

    localparam int DW = $clog2(DEPTH);
    localparam logic [DW-1:0] TOP = DW'(DEPTH - 1);

    logic [N_CORES-1:0] mask_q   [DEPTH];
    logic [N_CORES-1:0] mask_d   [DEPTH];
    logic [N_CORES-1:0] parent_q [DEPTH];
    logic [N_CORES-1:0] parent_d [DEPTH];
    logic [PC_W-1:0]    rpc_q    [DEPTH];
    logic [PC_W-1:0]    rpc_d    [DEPTH];
    logic [DEPTH-1:0]   else_done_q, else_done_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic [2:0]         err_q, err_d;

    logic [2:0]         n_cmd;
    logic [DW-1:0]      depth_up;
    logic [2:0]         err_new;

    // Decode the command, apply it to the stack if legal, else flag an error.
    always_comb begin
        mask_d      = mask_q;
        parent_d    = parent_q;
        rpc_d       = rpc_q;
        else_done_d = else_done_q;
        depth_d     = depth_q;
        err_new     = '0;
        depth_up    = depth_q + DW'(1);
        n_cmd       = 3'(load) + 3'(push) + 3'(els) + 3'(pop);

        if (n_cmd > 3'd1) begin
            err_new[2] = 1'b1;
        end else if (load) begin
            if (depth_q != '0) begin
                err_new[2] = 1'b1;
            end else begin
                mask_d[0]   = d_in;
                parent_d[0] = d_in;
            end
        end else if (push) begin
            if (depth_q == TOP) begin
                err_new[0] = 1'b1;
            end else begin
                mask_d[depth_up]      = d_in & mask_q[depth_q];
                parent_d[depth_up]    = mask_q[depth_q];
                rpc_d[depth_up]       = rpc_in;
                else_done_d[depth_up] = 1'b0;
                depth_d               = depth_up;
            end
        end else if (els) begin
            if (depth_q == '0 || else_done_q[depth_q]) begin
                err_new[2] = 1'b1;
            end else begin
                mask_d[depth_q]      = parent_q[depth_q] & ~mask_q[depth_q];
                else_done_d[depth_q] = 1'b1;
            end
        end else if (pop) begin
            if (depth_q == '0) begin
                err_new[1] = 1'b1;
            end else begin
                depth_d = depth_q - DW'(1);
            end
        end

        // A new error in the same cycle as err_clr must survive the clear.
        err_d = (err_clr ? 3'b000 : err_q) | err_new;
    end

    // State registers; base entry resets to an all-active, else-taken level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mask_q[i]   <= '1;
                parent_q[i] <= '1;
                rpc_q[i]    <= '0;
            end
            else_done_q <= DEPTH'(1);
            depth_q     <= '0;
            err_q       <= '0;
        end else begin
            mask_q      <= mask_d;
            parent_q    <= parent_d;
            rpc_q       <= rpc_d;
            else_done_q <= else_done_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
        end
    end

    // Outputs derive from registered state only.
    always_comb begin
        tos_mask  = mask_q[depth_q];
        tos_pc    = rpc_q[depth_q];
        depth     = depth_q;
        empty     = (depth_q == '0);
        full      = (depth_q == TOP);
        all_true  = &(mask_q[depth_q] | ~parent_q[depth_q]);
        all_false = (mask_q[depth_q] == '0);
        err       = err_q;
    end

endmodule

// File: tb/tb_simt_div_stack.sv
`timescale 1ns/1ps
// Bench for simt_div_stack: directed steps followed by random commands,
// checked against a queue-based stack model.
module tb_simt_div_stack;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int PW = 16;
    localparam int DW = $clog2(D);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load, push, els, pop, err_clr;
    logic [N-1:0]  d_in;
    logic [PW-1:0] rpc_in;
    logic [N-1:0]  tos_mask;
    logic [PW-1:0] tos_pc;
    logic [DW-1:0] depth;
    logic          empty, full, all_true, all_false;
    logic [2:0]    err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: one queue element per nesting level.
    logic [N-1:0]  m_mask [$];
    logic [N-1:0]  m_par  [$];
    logic [PW-1:0] m_rpc  [$];
    bit            m_ed   [$];
    logic [2:0]    m_err;

    simt_div_stack #(.N_CORES(N), .DEPTH(D), .PC_W(PW)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .push(push), .els(els),
        .pop(pop), .d_in(d_in), .rpc_in(rpc_in), .err_clr(err_clr),
        .tos_mask(tos_mask), .tos_pc(tos_pc), .depth(depth), .empty(empty),
        .full(full), .all_true(all_true), .all_false(all_false), .err(err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mask.delete(); m_par.delete(); m_rpc.delete(); m_ed.delete();
        m_mask.push_back('1); m_par.push_back('1);
        m_rpc.push_back('0);  m_ed.push_back(1'b1);
        m_err = 3'b000;
    endtask

    task automatic model_cmd(input bit l, input bit p, input bit e, input bit po,
                             input logic [N-1:0] d, input logic [PW-1:0] r, input bit clr);
        logic [2:0] e_new = 3'b000;
        int top = m_mask.size() - 1;
        if (int'(l) + int'(p) + int'(e) + int'(po) > 1) e_new[2] = 1'b1;
        else if (l) begin
            if (top != 0) e_new[2] = 1'b1;
            else begin m_mask[0] = d; m_par[0] = d; end
        end else if (p) begin
            if (m_mask.size() == D) e_new[0] = 1'b1;
            else begin
                m_par.push_back(m_mask[top]);
                m_mask.push_back(d & m_mask[top]);
                m_rpc.push_back(r);
                m_ed.push_back(1'b0);
            end
        end else if (e) begin
            if (top == 0 || m_ed[top]) e_new[2] = 1'b1;
            else begin m_mask[top] = m_par[top] & ~m_mask[top]; m_ed[top] = 1'b1; end
        end else if (po) begin
            if (top == 0) e_new[1] = 1'b1;
            else begin
                void'(m_mask.pop_back()); void'(m_par.pop_back());
                void'(m_rpc.pop_back());  void'(m_ed.pop_back());
            end
        end
        m_err = (clr ? 3'b000 : m_err) | e_new;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int top = m_mask.size() - 1;
        chk({tag, ".tos_mask"},  32'(tos_mask),  32'(m_mask[top]));
        chk({tag, ".tos_pc"},    32'(tos_pc),    32'(m_rpc[top]));
        chk({tag, ".depth"},     32'(depth),     32'(top));
        chk({tag, ".empty"},     32'(empty),     32'(top == 0));
        chk({tag, ".full"},      32'(full),      32'(top == D - 1));
        chk({tag, ".all_true"},  32'(all_true),  32'((m_mask[top] | ~m_par[top]) == {N{1'b1}}));
        chk({tag, ".all_false"}, 32'(all_false), 32'(m_mask[top] == '0));
        chk({tag, ".err"},       32'(err),       32'(m_err));
    endtask

    task automatic step(input string tag, input bit l, input bit p, input bit e, input bit po,
                        input logic [N-1:0] d, input logic [PW-1:0] r, input bit clr);
        load = l; push = p; els = e; pop = po; d_in = d; rpc_in = r; err_clr = clr;
        @(posedge clk);
        model_cmd(l, p, e, po, d, r, clr);
        #1;
        load = 0; push = 0; els = 0; pop = 0; err_clr = 0;
        check_all(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        load = 0; push = 0; els = 0; pop = 0; err_clr = 0; d_in = '0; rpc_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) reset_n = 1'b1;

        // Basic load / push / els / pop
        step("load",  1, 0, 0, 0, 4'b0111, 16'h0,  0);
        chk("load.mask_literal", 32'(tos_mask), 32'h7);
        step("push",  0, 1, 0, 0, 4'b1010, 16'h40, 0);
        chk("push.mask_literal", 32'(tos_mask), 32'h2);
        chk("push.pc_literal",   32'(tos_pc),   32'h40);
        step("els",   0, 0, 1, 0, 4'b0000, 16'h0,  0);
        chk("els.mask_literal",  32'(tos_mask), 32'h5);
        step("pop",   0, 0, 0, 1, 4'b0000, 16'h0,  0);

        // Fill to full, overflow, drain, underflow, clear
        for (int i = 0; i < D - 1; i++)
            step("fill", 0, 1, 0, 0, N'($urandom), PW'($urandom), 0);
        step("ovf", 0, 1, 0, 0, 4'b1111, 16'h1234, 0);
        chk("ovf.err_literal", 32'(err), 32'b001);
        for (int i = 0; i < D - 1; i++)
            step("drain", 0, 0, 0, 1, 4'b0, 16'h0, 0);
        step("udf", 0, 0, 0, 1, 4'b0, 16'h0, 0);
        chk("udf.err_literal", 32'(err), 32'b011);
        step("clr", 0, 0, 0, 0, 4'b0, 16'h0, 1);

        // Illegal sequences
        step("els_base",  0, 0, 1, 0, 4'b0, 16'h0, 0);
        step("clr1",      0, 0, 0, 0, 4'b0, 16'h0, 1);
        step("push_a",    0, 1, 0, 0, 4'b1100, 16'h80, 0);
        step("els_a",     0, 0, 1, 0, 4'b0, 16'h0, 0);
        step("els_twice", 0, 0, 1, 0, 4'b0, 16'h0, 0);
        step("push_pop",  0, 1, 0, 1, 4'b1111, 16'h99, 1);
        step("push_b",    0, 1, 0, 0, 4'b1111, 16'h90, 1);
        step("load_d2",   1, 0, 0, 0, 4'b1001, 16'h0, 0);
        step("pop_b",     0, 0, 0, 1, 4'b0, 16'h0, 0);
        step("pop_a",     0, 0, 0, 1, 4'b0, 16'h0, 1);

        // Zero-mask push then else-path
        step("push_zero", 0, 1, 0, 0, 4'b0000, 16'h55, 0);
        step("els_zero",  0, 0, 1, 0, 4'b0, 16'h0, 0);
        step("pop_zero",  0, 0, 0, 1, 4'b0, 16'h0, 0);

        // Asynchronous reset mid-nest at depth 3
        for (int i = 0; i < 3; i++)
            step("nest", 0, 1, 0, 0, N'($urandom), PW'($urandom), 0);
        step("err_pre_rst", 0, 0, 1, 1, 4'b0, 16'h0, 0);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk) reset_n = 1'b1;

        // Random commands
        for (int i = 0; i < 400; i++) begin
            int unsigned sel = $urandom_range(0, 15);
            logic [3:0] c = 4'b0000;
            case (sel)
                0, 1, 2, 3: c = 4'b0100;
                4, 5, 6:    c = 4'b0001;
                7, 8:       c = 4'b0010;
                9:          c = 4'b1000;
                10:         c = 4'($urandom);
                default:    c = 4'b0000;
            endcase
            step("rand", c[3], c[2], c[1], c[0], N'($urandom), PW'($urandom),
                 ($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
